// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int DMEM_DW = 32;
    localparam int DMEM_AW = 32;

    typedef logic port_id_t;
    localparam port_id_t PORT_MEM = 1'b0;
    localparam port_id_t PORT_AUX = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int DW = DMEM_DW,
    parameter int AW = DMEM_AW
) ();

    logic          p0_req,    p1_req;
    logic          p0_we,     p1_we;
    logic [AW-1:0] p0_addr,   p1_addr;
    logic [DW-1:0] p0_wdata,  p1_wdata;
    logic          p0_gnt,    p1_gnt;
    logic          p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata,  p1_rdata;
    logic          p0_stall;

    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] Address;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ReadData,
        output p0_gnt, p0_rvalid, p0_rdata, p0_stall,
        output p1_gnt, p1_rvalid, p1_rdata,
        output MemRead, MemWrite, Address, WriteData
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ReadData,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_stall,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  MemRead, MemWrite, Address, WriteData
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational port picker. DMEM_ARB_RR_EN selects round-robin on contention;
// otherwise port 0 has fixed priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_id_t   last_i,
    output port_id_t   gnt_id_o,
    output logic       any_req_o
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        any_req_o = |req_i;
        gnt_id_o  = PORT_MEM;
        if (req_i == 2'b11) begin
            gnt_id_o = (last_i == PORT_MEM) ? PORT_AUX : PORT_MEM;
        end else if (req_i[1]) begin
            gnt_id_o = PORT_AUX;
        end
    end
`else
    // The last-granted id is still tracked by the top but plays no part here.
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        any_req_o = |req_i;
        gnt_id_o  = PORT_MEM;
        if (!req_i[0] && req_i[1]) begin
            gnt_id_o = PORT_AUX;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the MEM stage (port 0) and an
// auxiliary master (port 1); reads take a one-cycle return state.
// Contention policy is chosen by DMEM_ARB_RR_EN inside dmem_arb_pick.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW = DMEM_DW,
    parameter int AW = DMEM_AW
) (
    input  logic           Clk,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);

    arb_state_t    state_q, state_d;
    port_id_t      owner_q, owner_d;
    port_id_t      last_q,  last_d;

    port_id_t      gnt_id;
    logic          any_req;
    logic [1:0]    req;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          p0_done;

    assign req = {bus.p1_req, bus.p0_req};

    dmem_arb_pick u_pick (
        .req_i     (req),
        .last_i    (last_q),
        .gnt_id_o  (gnt_id),
        .any_req_o (any_req)
    );

    assign sel_we    = (gnt_id == PORT_AUX) ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = (gnt_id == PORT_AUX) ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = (gnt_id == PORT_AUX) ? bus.p1_wdata : bus.p0_wdata;

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= PORT_MEM;
            last_q  <= PORT_AUX;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt       = '0;
        rvalid    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Holding everything quiet during Reset also drops any pending read.
        if (!Reset) begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt[gnt_id] = 1'b1;
                        mem_write   = sel_we;
                        mem_read    = ~sel_we;
                        mem_addr    = sel_addr;
                        mem_wdata   = sel_wdata;
                        last_d      = gnt_id;
                        if (!sel_we) begin
                            owner_d = gnt_id;
                            state_d = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign p0_done = (gnt[0] & bus.p0_we) | rvalid[0];

    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];
    assign bus.p0_rvalid = rvalid[0];
    assign bus.p1_rvalid = rvalid[1];
    assign bus.p0_rdata  = rvalid[0] ? bus.ReadData : '0;
    assign bus.p1_rdata  = rvalid[1] ? bus.ReadData : '0;
    assign bus.p0_stall  = ~Reset & bus.p0_req & ~p0_done;

    assign bus.MemRead   = mem_read;
    assign bus.MemWrite  = mem_write;
    assign bus.Address   = mem_addr;
    assign bus.WriteData = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// two-port traffic, all checked against a transaction-level reference model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 35) ? 32'd77 : (32'hA000 + i);
    endfunction

    // Memory device: read data appears the cycle after the MemRead cycle.
    logic [31:0] mem [64];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (bus.MemWrite) begin
            mem[bus.Address[5:0]] <= bus.WriteData;
        end
        if (bus.MemRead) rd_q <= mem[bus.Address[5:0]];
    end
    assign bus.ReadData = rd_q;

    // Reference model state: expected memory contents, pending read, last winner.
    logic [31:0] ref_mem [64];
    int          pend_port;
    logic [31:0] pend_data;
    int          last_port;
    logic        done0_m, done1_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compute the expected outputs for the current cycle's inputs and compare.
    task automatic eval();
        logic        e_g0, e_g1, e_v0, e_v1, e_mr, e_mw, e_st, we;
        logic [31:0] e_a, e_wd, e_r0, e_r1, addr, wd;
        logic [1:0]  rq;
        int          win;
        #1;
        {e_g0, e_g1, e_v0, e_v1, e_mr, e_mw} = '0;
        e_a = '0; e_wd = '0; e_r0 = '0; e_r1 = '0;
        rq = {bus.p1_req, bus.p0_req};
        if (rst) begin
            pend_port = -1;
            last_port = 1;
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        end else if (pend_port >= 0) begin
            if (pend_port == 0) begin e_v0 = 1'b1; e_r0 = pend_data; end
            else                begin e_v1 = 1'b1; e_r1 = pend_data; end
            pend_port = -1;
        end else if (rq != 2'b00) begin
            if (rq == 2'b11) win = RR_MODE ? (1 - last_port) : 0;
            else             win = rq[1] ? 1 : 0;
            we   = (win == 1) ? bus.p1_we    : bus.p0_we;
            addr = (win == 1) ? bus.p1_addr  : bus.p0_addr;
            wd   = (win == 1) ? bus.p1_wdata : bus.p0_wdata;
            if (win == 1) e_g1 = 1'b1; else e_g0 = 1'b1;
            e_mw = we; e_mr = ~we; e_a = addr; e_wd = wd;
            last_port = win;
            if (we) ref_mem[addr[5:0]] = wd;
            else begin pend_port = win; pend_data = ref_mem[addr[5:0]]; end
        end
        done0_m = (e_g0 & bus.p0_we) | e_v0;
        done1_m = (e_g1 & bus.p1_we) | e_v1;
        e_st    = ~rst & bus.p0_req & ~done0_m;

        check("p0_gnt",    bus.p0_gnt,    e_g0);
        check("p1_gnt",    bus.p1_gnt,    e_g1);
        check("p0_rvalid", bus.p0_rvalid, e_v0);
        check("p1_rvalid", bus.p1_rvalid, e_v1);
        check("MemRead",   bus.MemRead,   e_mr);
        check("MemWrite",  bus.MemWrite,  e_mw);
        check("p0_stall",  bus.p0_stall,  e_st);
        if (!rst) begin
            check("p0_rdata",  bus.p0_rdata,  e_r0);
            check("p1_rdata",  bus.p1_rdata,  e_r1);
            check("Address",   bus.Address,   e_a);
            check("WriteData", bus.WriteData, e_wd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
    endtask

    initial begin
        logic act0, act1;
        int   first_id, stall_cnt, p1_gnts;

        pend_port = -1;
        last_port = 1;
        rst = 1'b1;
        set_p0(1'b1, 1'b0, 32'd3, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;

        // Reset held with a request present: everything quiet.
        eval();
        check("rst_p0_gnt",   bus.p0_gnt,   1'b0);
        check("rst_p0_stall", bus.p0_stall, 1'b0);
        tick();
        eval();
        tick();

        // Idle after reset.
        rst = 1'b0;
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        eval();
        check("idle_Address", bus.Address, 32'd0);
        tick();

        // Uncontended p0 write.
        set_p0(1'b1, 1'b1, 32'd5, 32'hAB);
        eval();
        check("wr_gnt",      bus.p0_gnt,    1'b1);
        check("wr_MemWrite", bus.MemWrite,  1'b1);
        check("wr_Address",  bus.Address,   32'd5);
        check("wr_WData",    bus.WriteData, 32'hAB);
        check("wr_stall",    bus.p0_stall,  1'b0);
        tick();

        // Uncontended p0 read of addr 35, held through the return cycle.
        set_p0(1'b1, 1'b0, 32'd35, 32'd0);
        eval();
        check("rd_gnt",     bus.p0_gnt,   1'b1);
        check("rd_MemRead", bus.MemRead,  1'b1);
        check("rd_stall",   bus.p0_stall, 1'b1);
        tick();
        eval();
        check("rd_rvalid",  bus.p0_rvalid, 1'b1);
        check("rd_rdata",   bus.p0_rdata,  32'd77);
        check("rd_stall2",  bus.p0_stall,  1'b0);
        check("rd_no_regnt", bus.p0_gnt,   1'b0);
        tick();

        // Contention after last=0: p1 write against p0 read.
        set_p0(1'b1, 1'b0, 32'd7, 32'd0);
        set_p1(1'b1, 1'b1, 32'd9, 32'h1234);
        act0 = 1'b1; act1 = 1'b1; first_id = -1; stall_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            bus.p0_req = act0;
            bus.p1_req = act1;
            eval();
            if (first_id < 0 && (bus.p0_gnt || bus.p1_gnt)) first_id = bus.p1_gnt ? 1 : 0;
            stall_cnt += int'(bus.p0_stall);
            if (done0_m) act0 = 1'b0;
            if (done1_m) act1 = 1'b0;
            tick();
        end
        check("cont_first", first_id, RR_MODE ? 1 : 0);
        check("cont_stall", stall_cnt, RR_MODE ? 2 : 1);

        // Reset during the read return cycle.
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        set_p0(1'b1, 1'b0, 32'd10, 32'd0);
        eval();
        tick();
        rst = 1'b1;
        eval();
        check("rstrd_rvalid", bus.p0_rvalid, 1'b0);
        tick();
        rst = 1'b0;
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        eval();
        check("rstrd_after", bus.p0_rvalid, 1'b0);
        tick();
        set_p1(1'b1, 1'b1, 32'd2, 32'h55);
        eval();
        check("rstrd_idle_gnt", bus.p1_gnt, 1'b1);
        tick();
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        eval();
        tick();

        // Both ports reading continuously; last=1 so p0 takes slot 0.
        set_p0(1'b1, 1'b0, 32'd3, 32'd0);
        set_p1(1'b1, 1'b0, 32'd4, 32'd0);
        p1_gnts = 0;
        for (int c = 0; c < 16; c++) begin
            eval();
            if (c % 2 == 0) begin
                check("cont_rd_p0", bus.p0_gnt, (!RR_MODE || (c % 4 == 0)) ? 1'b1 : 1'b0);
            end
            p1_gnts += int'(bus.p1_gnt);
            tick();
        end
        check("cont_rd_p1_count", p1_gnts, RR_MODE ? 4 : 0);
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        for (int c = 0; c < 2; c++) begin
            eval();
            tick();
        end

        // Random traffic: each port holds a transaction until its done.
        act0 = 1'b0; act1 = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!act0 && $urandom_range(0, 3) != 0) begin
                act0 = 1'b1;
                set_p0(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
            end
            if (!act1 && $urandom_range(0, 2) != 0) begin
                act1 = 1'b1;
                set_p1(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
            end
            bus.p0_req = act0;
            bus.p1_req = act1;
            eval();
            if (done0_m) act0 = 1'b0;
            if (done1_m) act1 = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer sharing the single-port data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is a secondary master (program/data loader, debug access). It issues MemRead/MemWrite/Address/WriteData to the data memory and routes read data back to the port that requested it. It also generates the MEM-stage stall. A small FSM covers the read return cycle.

## Interface
Parameters:
- DW, 32, data width of memory words and port data.
- AW, 32, address width; the address is a word index passed unchanged to the memory.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- p0_req / p1_req  in  1  transaction request; held until the transaction completes.
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req is high.
- p0_addr / p1_addr  in  AW  word address; stable while req is high.
- p0_wdata / p1_wdata  in  DW  write data; stable while req is high.
- p0_gnt / p1_gnt  out  1  request accepted this cycle.
- p0_rvalid / p1_rvalid  out  1  read data valid this cycle (one-cycle pulse).
- p0_rdata / p1_rdata  out  DW  read data; meaningful only with rvalid.
- p0_stall  out  1  MEM-stage stall: p0_req & ~p0_done.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- Address  out  AW  memory address.
- WriteData  out  DW  memory write data.
- ReadData  in  DW  memory read data; valid the cycle after the MemRead cycle.

## Operation
- FSM states: IDLE, RD_WAIT. Internal registers: state, owner (port id of the pending read), last (port last granted).
- IDLE, no request: all strobes 0. Address and WriteData are 0.
- IDLE, one or more requests: the picker chooses one port x and asserts px_gnt.
  - Address, WriteData and the strobes are driven combinationally from port x in the same cycle.
  - MemWrite = px_we; MemRead = ~px_we.
  - last <= x.
- Write grant: the transaction is complete in the grant cycle. State stays IDLE, so a new grant is possible the next cycle.
- Read grant: owner <= x and state goes to RD_WAIT.
- RD_WAIT (exactly one cycle):
  - Assert p[owner]_rvalid, with p[owner]_rdata = ReadData (combinational pass-through).
  - No grants and no strobes; return to IDLE.
  - A req from the owner in this cycle is the pending transaction, not a new one.
- Completion for port x is px_done = (px_gnt & px_we) | px_rvalid. The requester may deassert req, or present a new transaction, from the next cycle.
- Outside rvalid cycles, rdata outputs are 0.
- Contention resolution (both ports requesting in IDLE) is set by the Configuration section.
- Reset: state = IDLE, owner = 0, last = 1 (port 0 wins the first contention in both modes). All gnt, rvalid, strobes and stall are 0 while Reset is high.
- Reset asserted during RD_WAIT: the pending read is dropped and no rvalid is ever issued for it.

## Timing
- Write: granted and completed in the request cycle when uncontended; 1 cycle throughput.
- Read: grant in cycle N, rvalid in cycle N+1, earliest next grant in N+2. Throughput is 1 read per 2 cycles.
- p0_stall is combinational. An uncontended port-0 read stalls exactly 1 cycle (the grant cycle); an uncontended write stalls 0 cycles.
- A losing requester waits; its stall stays high until its own done.
- The port 1 interface is the same, with no stall output.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On contention, grant the port ≠ last.
- DMEM_ARB_RR_EN undefined: fixed priority. Port 0 always wins contention. The last register is still maintained but is unused for arbitration.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum {IDLE, RD_WAIT};
  - port id constants PORT_MEM = 0 and PORT_AUX = 1;
  - default widths DW/AW.
- Sub-module dmem_arb_pick: combinational picker. Inputs: req[1:0], last. Outputs: gnt_id and any_req. The DMEM_ARB_RR_EN switch lives there. The FSM, owner/last registers and data routing live in dmem_arbiter.

## Test plan
- Reset, then idle → all outputs 0. After Reset is released, uncontended p0 write with addr 5, wdata 0xAB: p0_gnt=1, MemWrite=1, Address=5, WriteData=0xAB in the same cycle; p0_stall=0.
- p0 read of addr 35, memory returns 77 → gnt in cycle N with MemRead=1 and p0_stall=1. In N+1: p0_rvalid=1, p0_rdata=77, p0_stall=0.
- p0 and p1 both read continuously with DMEM_ARB_RR_EN defined → grants alternate p0, p1, p0, ... every 2 cycles, with no rvalid sent to the wrong port. Without the macro: p0 granted every read slot and p1 never granted.
- p1 write and p0 read requested in the same IDLE cycle, after last=0 (round-robin) → p1 granted first; p0 granted the next cycle; p0_stall high for 2 cycles in total.
- Reset asserted in the RD_WAIT cycle → no rvalid; state IDLE and all outputs 0 on the next cycle.
- Owner holds p0_req during RD_WAIT → no second grant or strobe; exactly one rvalid.
